wb_commit_stage: RTL and testbench

//  Writeback/commit stage of the 5-stage LoongArch pipeline, directly upstream of the CSR file.

---
 rtl/wb_commit_stage_pkg.sv | 43 ++++
 rtl/wb_commit_stage.sv | 118 +++++++++++
 tb/tb_wb_commit_stage.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_commit_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wb_commit_stage_pkg
// Brief   : Bus widths, field layouts and ECODE values for the WB commit stage
// Revision: 1.0 - initial release
// ============================================================================
package wb_commit_stage_pkg;

    localparam int MEM2WB_LEN = 167;
    localparam int WB2CSR_LEN = 49;

    localparam logic [5:0] ECODE_INT = 6'h00;
    localparam logic [5:0] ECODE_ADE = 6'h08;
    localparam logic [5:0] ECODE_ALE = 6'h09;
    localparam logic [5:0] ECODE_SYS = 6'h0b;

    // Field order is MSB first, matching the MEM->WB bus wire layout.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] result;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic        csr_re;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wvalue;
        logic        ex;
        logic [5:0]  ecode;
        logic [8:0]  esubcode;
        logic        ertn;
    } mem2wb_t;

    typedef struct packed {
        logic        ertn_flush;
        logic        wb_ex;
        logic [5:0]  ecode;
        logic [8:0]  esubcode;
        logic [31:0] pc;
    } wb2csr_t;

endpackage
`default_nettype wire

// File: rtl/wb_commit_stage.sv
`default_nettype none
// ============================================================================
// Module  : wb_commit_stage
// Brief   : Writeback/commit stage: GPR/CSR write, exception/ertn flush, trace
// Revision: 1.0 - initial release
// ============================================================================
module wb_commit_stage
    import wb_commit_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC_UNUSED = 32'h1c000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_to_wb_valid,
    output logic                  wb_allowin,
    input  logic [MEM2WB_LEN-1:0] mem_to_wb_bus,
    output logic                  rf_we,
    output logic [4:0]            rf_waddr,
    output logic [31:0]           rf_wdata,
    output logic                  csr_re,
    output logic [13:0]           csr_num,
    input  logic [31:0]           csr_rvalue,
    output logic                  csr_we,
    output logic [31:0]           csr_wmask,
    output logic [31:0]           csr_wvalue,
    output logic [WB2CSR_LEN-1:0] csr_in_bus,
    input  logic [31:0]           ex_entry,
    input  logic [31:0]           ertn_entry,
    output logic                  flush,
    output logic [31:0]           flush_target,
    output logic [31:0]           retired_cnt,
    output logic [31:0]           debug_wb_pc,
    output logic [3:0]            debug_wb_rf_we,
    output logic [4:0]            debug_wb_rf_wnum,
    output logic [31:0]           debug_wb_rf_wdata
);

    localparam logic READY_GO = 1'b1;

    logic        wb_valid_q, wb_valid_d;
    mem2wb_t     payload_q, payload_d;
    logic [31:0] retired_cnt_q, retired_cnt_d;

    logic        commit_ex;
    logic        commit_ertn;
    wb2csr_t     csr_bus;

    assign wb_allowin = ~wb_valid_q | READY_GO;

    always_comb begin
        wb_valid_d    = wb_valid_q;
        payload_d     = payload_q;
        retired_cnt_d = retired_cnt_q;
        // A committing exception/ertn discards whatever MEM offers this cycle.
        if (flush) begin
            wb_valid_d = 1'b0;
        end else if (wb_allowin) begin
            wb_valid_d = mem_to_wb_valid;
        end
        if (mem_to_wb_valid && wb_allowin) begin
            payload_d = mem2wb_t'(mem_to_wb_bus);
        end
        if (wb_valid_q && !payload_q.ex) begin
            retired_cnt_d = retired_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid_q    <= 1'b0;
            retired_cnt_q <= 32'd0;
        end else begin
            wb_valid_q    <= wb_valid_d;
            retired_cnt_q <= retired_cnt_d;
        end
    end

    // Payload is don't-care while wb_valid_q is low, so it carries no reset.
    always_ff @(posedge clk) begin
        payload_q <= payload_d;
    end

    always_comb begin
        commit_ex   = wb_valid_q & payload_q.ex;
        commit_ertn = wb_valid_q & payload_q.ertn & ~payload_q.ex;

        flush        = commit_ex | commit_ertn;
        flush_target = commit_ex ? ex_entry : ertn_entry;

        csr_bus            = '0;
        csr_bus.ertn_flush = commit_ertn;
        csr_bus.wb_ex      = commit_ex;
        if (wb_valid_q) begin
            csr_bus.ecode    = payload_q.ecode;
            csr_bus.esubcode = payload_q.esubcode;
            csr_bus.pc       = payload_q.pc;
        end
        csr_in_bus = csr_bus;

        rf_we    = wb_valid_q & payload_q.rf_we & ~payload_q.ex;
        rf_waddr = payload_q.rf_waddr;
        rf_wdata = payload_q.csr_re ? csr_rvalue : payload_q.result;

        csr_re     = wb_valid_q & payload_q.csr_re & ~payload_q.ex;
        csr_we     = wb_valid_q & payload_q.csr_we & ~payload_q.ex;
        csr_num    = payload_q.csr_num;
        csr_wmask  = payload_q.csr_wmask;
        csr_wvalue = payload_q.csr_wvalue;

        retired_cnt       = retired_cnt_q;
        debug_wb_pc       = wb_valid_q ? payload_q.pc : RESET_PC_UNUSED;
        debug_wb_rf_we    = {4{rf_we}};
        debug_wb_rf_wnum  = rf_waddr;
        debug_wb_rf_wdata = rf_wdata;
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_commit_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_wb_commit_stage
// Brief   : Directed plus randomized bench for wb_commit_stage with a
//           transaction-level model of the WB slot and retire counter
// Revision: 1.0 - initial release
// ============================================================================
module tb_wb_commit_stage;
    import wb_commit_stage_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h1c000000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  reset;
    logic                  mem_to_wb_valid;
    logic                  wb_allowin;
    logic [MEM2WB_LEN-1:0] mem_to_wb_bus;
    logic                  rf_we;
    logic [4:0]            rf_waddr;
    logic [31:0]           rf_wdata;
    logic                  csr_re;
    logic [13:0]           csr_num;
    logic [31:0]           csr_rvalue;
    logic                  csr_we;
    logic [31:0]           csr_wmask;
    logic [31:0]           csr_wvalue;
    logic [WB2CSR_LEN-1:0] csr_in_bus;
    logic [31:0]           ex_entry;
    logic [31:0]           ertn_entry;
    logic                  flush;
    logic [31:0]           flush_target;
    logic [31:0]           retired_cnt;
    logic [31:0]           debug_wb_pc;
    logic [3:0]            debug_wb_rf_we;
    logic [4:0]            debug_wb_rf_wnum;
    logic [31:0]           debug_wb_rf_wdata;

    wb_commit_stage #(.RESET_PC_UNUSED(RESET_PC)) dut (
        .clk(clk), .reset(reset),
        .mem_to_wb_valid(mem_to_wb_valid), .wb_allowin(wb_allowin),
        .mem_to_wb_bus(mem_to_wb_bus),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .csr_re(csr_re), .csr_num(csr_num), .csr_rvalue(csr_rvalue),
        .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
        .csr_in_bus(csr_in_bus), .ex_entry(ex_entry), .ertn_entry(ertn_entry),
        .flush(flush), .flush_target(flush_target), .retired_cnt(retired_cnt),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the instruction sitting in WB (if any) and how many have retired.
    logic        m_valid;
    mem2wb_t     m_ins;
    logic [31:0] m_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic mem2wb_t mk(input logic [31:0] pc, input logic [31:0] result,
                                   input logic we, input logic [4:0] wa,
                                   input logic cre, input logic cwe, input logic [13:0] cnum,
                                   input logic [31:0] cmask, input logic [31:0] cval,
                                   input logic ex, input logic [5:0] ecode, input logic ertn);
        mem2wb_t b;
        b.pc = pc; b.result = result; b.rf_we = we; b.rf_waddr = wa;
        b.csr_re = cre; b.csr_we = cwe; b.csr_num = cnum;
        b.csr_wmask = cmask; b.csr_wvalue = cval;
        b.ex = ex; b.ecode = ecode; b.esubcode = 9'h0; b.ertn = ertn;
        return b;
    endfunction

    task automatic check_outputs();
        logic is_exc, is_ertn, commits;
        logic [48:0] bus_exp;
        is_exc  = m_valid && m_ins.ex;
        is_ertn = m_valid && m_ins.ertn && !m_ins.ex;
        commits = m_valid && !m_ins.ex;
        bus_exp = m_valid ? {is_ertn, is_exc, m_ins.ecode, m_ins.esubcode, m_ins.pc} : 49'h0;
        chk("allowin", wb_allowin, 1);
        chk("flush", flush, is_exc || is_ertn);
        if (is_exc || is_ertn) chk("flush_target", flush_target, is_exc ? ex_entry : ertn_entry);
        chk("rf_we", rf_we, commits && m_ins.rf_we);
        chk("csr_re", csr_re, commits && m_ins.csr_re);
        chk("csr_we", csr_we, commits && m_ins.csr_we);
        chk("dbg_we", debug_wb_rf_we, (commits && m_ins.rf_we) ? 4'hf : 4'h0);
        chk("csr_in_bus", csr_in_bus, bus_exp);
        chk("retired_cnt", retired_cnt, m_cnt);
        chk("dbg_pc", debug_wb_pc, m_valid ? m_ins.pc : RESET_PC);
        if (m_valid) begin
            chk("rf_waddr", rf_waddr, m_ins.rf_waddr);
            chk("rf_wdata", rf_wdata, m_ins.csr_re ? csr_rvalue : m_ins.result);
            chk("dbg_wnum", debug_wb_rf_wnum, m_ins.rf_waddr);
            chk("dbg_wdata", debug_wb_rf_wdata, m_ins.csr_re ? csr_rvalue : m_ins.result);
            chk("csr_num", csr_num, m_ins.csr_num);
            chk("csr_wmask", csr_wmask, m_ins.csr_wmask);
            chk("csr_wvalue", csr_wvalue, m_ins.csr_wvalue);
        end
    endtask

    // First half of a cycle: drive inputs and check the settled outputs.
    task automatic pre(input logic v, input mem2wb_t b, input logic rst);
        mem_to_wb_valid = v;
        mem_to_wb_bus   = b;
        reset           = rst;
        #1;
        check_outputs();
    endtask

    // Second half: clock edge, then advance the model with the same inputs.
    task automatic post();
        logic    was_flush, v, rst;
        mem2wb_t b;
        was_flush = m_valid && (m_ins.ex || m_ins.ertn);
        v   = mem_to_wb_valid;
        b   = mem2wb_t'(mem_to_wb_bus);
        rst = reset;
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0;
            m_cnt   = 32'd0;
        end else begin
            if (m_valid && !m_ins.ex) m_cnt = m_cnt + 32'd1;
            m_valid = was_flush ? 1'b0 : v;
        end
        if (v) m_ins = b;
        @(negedge clk);
    endtask

    task automatic cycle(input logic v, input mem2wb_t b, input logic rst);
        pre(v, b, rst);
        post();
    endtask

    mem2wb_t alu, csrwr, sys, ertn_i, both, filler, rnd;

    initial begin
        alu    = mk(32'h1c000010, 32'h5, 1, 5'd4, 0, 0, 14'h0, 32'h0, 32'h0, 0, 6'h0, 0);
        csrwr  = mk(32'h1c000014, 32'h0, 1, 5'd5, 1, 1, 14'h30, 32'hffffffff, 32'hdead, 0, 6'h0, 0);
        sys    = mk(32'h1c000100, 32'h0, 1, 5'd6, 0, 1, 14'h30, 32'hffffffff, 32'h1, 1, ECODE_SYS, 0);
        ertn_i = mk(32'h1c008010, 32'h0, 0, 5'd0, 0, 0, 14'h0, 32'h0, 32'h0, 0, 6'h0, 1);
        both   = mk(32'h1c000200, 32'h0, 0, 5'd0, 0, 0, 14'h0, 32'h0, 32'h0, 1, ECODE_ALE, 1);
        filler = mk(32'h1c000104, 32'h77, 1, 5'd7, 0, 0, 14'h0, 32'h0, 32'h0, 0, 6'h0, 0);

        csr_rvalue = 32'h0; ex_entry = 32'h1c008000; ertn_entry = 32'h1c000104;
        mem_to_wb_valid = 1'b0; mem_to_wb_bus = '0; reset = 1'b1;
        repeat (2) @(posedge clk);
        m_valid = 1'b0; m_cnt = 32'd0; m_ins = '0;
        @(negedge clk);

        // Reset state, then ALU commit.
        pre(1, alu, 0);
        chk("rst_dbg_pc", debug_wb_pc, RESET_PC);
        chk("rst_cnt", retired_cnt, 0);
        post();
        pre(1, csrwr, 0);
        chk("alu_we", rf_we, 1);
        chk("alu_wdata", rf_wdata, 32'h5);
        chk("alu_dbg_we", debug_wb_rf_we, 4'hf);
        chk("alu_noflush", flush, 0);
        post();

        // csrwr returns old CSR value to the GPR.
        csr_rvalue = 32'h1234;
        pre(1, sys, 0);
        chk("csrwr_we", csr_we, 1);
        chk("csrwr_num", csr_num, 14'h30);
        chk("csrwr_wdata", rf_wdata, 32'h1234);
        post();

        // syscall commit; younger instruction from MEM is dropped.
        pre(1, filler, 0);
        chk("sys_flush", flush, 1);
        chk("sys_target", flush_target, 32'h1c008000);
        chk("sys_bus", csr_in_bus, {1'b0, 1'b1, 6'h0b, 9'h0, 32'h1c000100});
        chk("sys_rf_we", rf_we, 0);
        chk("sys_csr_we", csr_we, 0);
        post();
        pre(1, ertn_i, 0);
        chk("sys_drop", debug_wb_pc, RESET_PC);
        chk("sys_drop_we", rf_we, 0);
        post();

        // ertn commit counts as retired.
        pre(0, filler, 0);
        chk("ertn_flush", flush, 1);
        chk("ertn_target", flush_target, 32'h1c000104);
        chk("ertn_bits", csr_in_bus[48:47], 2'b10);
        post();
        chk("ertn_cnt", retired_cnt, m_cnt);

        // ex and ertn both set: exception wins.
        cycle(1, both, 0);
        pre(0, filler, 0);
        chk("both_target", flush_target, ex_entry);
        chk("both_bits", csr_in_bus[48:47], 2'b01);
        post();

        // Reset while a valid instruction sits in WB.
        cycle(1, alu, 0);
        pre(1, filler, 1);
        post();
        pre(0, filler, 0);
        chk("mid_rst_we", rf_we, 0);
        chk("mid_rst_cnt", retired_cnt, 0);
        chk("mid_rst_pc", debug_wb_pc, RESET_PC);
        post();

        // Randomized traffic checked cycle by cycle against the model.
        for (int i = 0; i < 400; i++) begin
            rnd.pc = $urandom; rnd.result = $urandom;
            rnd.rf_we = 1'($urandom); rnd.rf_waddr = 5'($urandom);
            rnd.csr_re = 1'($urandom); rnd.csr_we = 1'($urandom);
            rnd.csr_num = 14'($urandom); rnd.csr_wmask = $urandom; rnd.csr_wvalue = $urandom;
            rnd.ex = ($urandom_range(0, 5) == 0); rnd.ecode = 6'($urandom);
            rnd.esubcode = 9'($urandom); rnd.ertn = ($urandom_range(0, 5) == 0);
            csr_rvalue = $urandom; ex_entry = $urandom; ertn_entry = $urandom;
            cycle($urandom_range(0, 3) != 0, rnd, $urandom_range(0, 49) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
